// File: rtl/fetch_prefetch_unit_pkg.sv
// fetch_prefetch_unit_pkg: shared types, opcode helpers, bus ID and fetch state for the fetch stage
package fetch_prefetch_unit_pkg;
  typedef logic [31:0] instruction_t;
  typedef logic [63:0] memory_address_t;
  typedef logic [63:0] execution_mask_t;
  typedef enum logic [5:0] {
    OP_NOP    = 6'h00,
    OP_ADD    = 6'h01,
    OP_SUB    = 6'h02,
    OP_LOAD   = 6'h08,
    OP_STORE  = 6'h09,
    OP_JMP    = 6'h10,
    OP_BRANCH = 6'h11,
    OP_CALL   = 6'h12,
    OP_RET    = 6'h13,
    OP_HALT   = 6'h3f
  } Opcode;
  typedef enum logic [3:0] {
    COMPONENT_TYPE_CORE  = 4'd0,
    COMPONENT_TYPE_FETCH = 4'd1,
    COMPONENT_TYPE_LSU   = 4'd2
  } component_type_t;
  typedef enum logic [2:0] {INIT, CHECK, REQ, WAIT_MEM, WAIT_REDIRECT} fetch_state_t;
  localparam execution_mask_t ALL_THREADS_EXEC_MASK = '1;
  function automatic Opcode getOpcode(input logic [5:0] op_bits);
    return Opcode'(op_bits);
  endfunction
  function automatic logic changesControlFlow(input Opcode op);
    return op inside {OP_JMP, OP_BRANCH, OP_CALL, OP_RET, OP_HALT};
  endfunction
  function automatic logic [15:0] createBusID(input logic [11:0] core_id, input component_type_t comp);
    return {core_id, comp};
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: power-of-two FIFO whose push space is judged on the registered count only
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: line-buffered fetch stage feeding decode through a prefetch queue, halting on control flow
module fetch_prefetch_unit import fetch_prefetch_unit_pkg::*; #(
  parameter int CORE_ID = 0,
  parameter int INSN_W = 32,
  parameter int INSNS_PER_LINE = 2,
  parameter int QUEUE_DEPTH = 4,
  parameter int ADDR_W = 64,
  parameter int MASK_W = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  output logic                             mem_req_valid,
  input  logic                             mem_req_ready,
  output logic [ADDR_W-1:0]                mem_req_addr,
  output logic [15:0]                      mem_req_id,
  input  logic                             mem_rsp_valid,
  input  logic [INSN_W*INSNS_PER_LINE-1:0] mem_rsp_data,
  input  logic                             redirect_valid,
  input  logic [ADDR_W-1:0]                redirect_pc,
  input  logic [MASK_W-1:0]                redirect_mask,
  output logic                             dec_valid,
  input  logic                             dec_ready,
  output logic [ADDR_W-1:0]                dec_pc,
  output logic [INSN_W-1:0]                dec_insn,
  output logic [MASK_W-1:0]                dec_mask,
  output logic [31:0]                      fill_wait_cycles,
  output logic                             protocol_error
);
  localparam int IB = INSN_W / 8;
  localparam int LB = IB * INSNS_PER_LINE;
  localparam int IB_SH = $clog2(IB);
  localparam int SW = INSNS_PER_LINE > 1 ? $clog2(INSNS_PER_LINE) : 1;
  localparam int LW = INSN_W * INSNS_PER_LINE;
  localparam int EW = ADDR_W + INSN_W + MASK_W;
  fetch_state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, line_addr, cur_line;
  logic [MASK_W-1:0] mask, mask_n;
  logic [LW-1:0] line_data;
  logic [SW-1:0] slot;
  logic [INSN_W-1:0] insn;
  logic [EW-1:0] head;
  logic line_valid, hit, cf, push, pop, load, full, empty, err_n;
  assign cur_line = pc & ~ADDR_W'(LB - 1);
  assign slot = SW'((pc >> IB_SH) & ADDR_W'(INSNS_PER_LINE - 1));
  assign insn = INSN_W'(line_data >> (INSN_W * slot));
  assign hit = line_valid && line_addr == cur_line;
  assign cf = changesControlFlow(getOpcode(insn[5:0]));
  assign mem_req_valid = state == REQ;
  assign mem_req_addr = cur_line;
  assign mem_req_id = createBusID(12'(CORE_ID), COMPONENT_TYPE_FETCH);
  assign dec_valid = !empty;
  assign pop = dec_valid && dec_ready;
  assign {dec_pc, dec_insn, dec_mask} = empty ? '0 : head;
  assign err_n = protocol_error
    || (redirect_valid && (state != WAIT_REDIRECT || (redirect_pc & ADDR_W'(IB - 1)) != '0))
    || (mem_rsp_valid && state != WAIT_MEM);
  always_comb begin
    state_n = state;
    pc_n = pc;
    mask_n = mask;
    push = 1'b0;
    load = 1'b0;
    case (state)
      INIT: state_n = CHECK;
      CHECK:
        if (!hit) state_n = REQ;
        else if (!full) begin
          push = 1'b1;
          pc_n = pc + ADDR_W'(IB);
          state_n = cf ? WAIT_REDIRECT : CHECK;
        end
      REQ: state_n = mem_req_ready ? WAIT_MEM : REQ;
      WAIT_MEM:
        if (mem_rsp_valid) begin
          load = 1'b1;
          state_n = CHECK;
        end
      WAIT_REDIRECT:
        if (redirect_valid) begin
          pc_n = redirect_pc & ~ADDR_W'(IB - 1);
          mask_n = redirect_mask;
          state_n = CHECK;
        end
      default: state_n = INIT;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= INIT;
      pc <= '0;
      mask <= '1;
      line_valid <= 1'b0;
      line_addr <= '0;
      line_data <= '0;
      fill_wait_cycles <= '0;
      protocol_error <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      mask <= mask_n;
      protocol_error <= err_n;
      if (load) begin
        line_valid <= 1'b1;
        line_addr <= cur_line;
        line_data <= mem_rsp_data;
      end
      if (state == WAIT_MEM && fill_wait_cycles != '1) fill_wait_cycles <= fill_wait_cycles + 32'd1;
    end
  fetch_queue #(.DEPTH(QUEUE_DEPTH), .W(EW)) u_queue (
    .clk(clk),
    .reset(reset),
    .push(push),
    .din({pc, insn, mask}),
    .pop(pop),
    .dout(head),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: directed checks of fetch, stall, redirect, fill statistics and error flagging
module tb_fetch_prefetch_unit;
  logic clk = 1'b0, reset = 1'b1;
  logic mem_req_valid, mem_req_ready = 1'b1, mem_rsp_valid = 1'b0;
  logic [63:0] mem_req_addr, mem_rsp_data = '0;
  logic [15:0] mem_req_id;
  logic redirect_valid = 1'b0, dec_valid, dec_ready = 1'b1, protocol_error;
  logic [63:0] redirect_pc = '0, redirect_mask = '0, dec_pc, dec_mask;
  logic [31:0] dec_insn, fill_wait_cycles;
  int n_pass = 0, n_fail = 0, n_chk = 0, rsp_delay = 1, resp_cnt = 0;
  logic [63:0] resp_addr = '0, jmp_addr = 64'hfff0;
  logic stray_rsp = 1'b0;
  logic [63:0] req_q[$], pc_q[$], mask_q[$];
  always #5 clk = ~clk;
  fetch_prefetch_unit dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_id(mem_req_id),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_mask(redirect_mask),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc),
    .dec_insn(dec_insn), .dec_mask(dec_mask),
    .fill_wait_cycles(fill_wait_cycles), .protocol_error(protocol_error)
  );
  function automatic logic [31:0] insn_at(input logic [63:0] a);
    return {a[23:0], (a == jmp_addr) ? 8'h10 : 8'h01};
  endfunction
  initial forever begin
    @(negedge clk);
    mem_rsp_valid = stray_rsp;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data = {insn_at(resp_addr + 64'd4), insn_at(resp_addr)};
      end
    end
    if (mem_req_valid && mem_req_ready) begin
      req_q.push_back(mem_req_addr);
      resp_addr = mem_req_addr;
      resp_cnt = rsp_delay;
    end
    if (dec_valid && dec_ready) begin
      pc_q.push_back(dec_pc);
      mask_q.push_back(dec_mask);
    end
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    redirect_valid = 1'b0;
    stray_rsp = 1'b0;
    resp_cnt = 0;
    step(2);
    req_q.delete();
    pc_q.delete();
    mask_q.delete();
  endtask
  task automatic redirect(input logic [63:0] p, input logic [63:0] m);
    redirect_valid = 1'b1;
    redirect_pc = p;
    redirect_mask = m;
    step(1);
    redirect_valid = 1'b0;
  endtask
  initial begin
    step(2);
    chk("rst_dec_valid", 64'(dec_valid), 64'h0);
    chk("rst_req_valid", 64'(mem_req_valid), 64'h0);
    chk("rst_dec_pc", dec_pc, 64'h0);
    chk("rst_dec_mask", dec_mask, 64'h0);
    chk("rst_fill_wait", 64'(fill_wait_cycles), 64'h0);
    chk("rst_perr", 64'(protocol_error), 64'h0);
    chk("bus_id", 64'(mem_req_id), 64'h1);
    reset = 1'b0;
    step(1);
    chk("check_no_req", 64'(mem_req_valid), 64'h0);
    step(1);
    chk("req_valid", 64'(mem_req_valid), 64'h1);
    chk("req_addr", mem_req_addr, 64'h0);
    step(2);
    chk("dec_not_yet", 64'(dec_valid), 64'h0);
    step(1);
    chk("dec_first_valid", 64'(dec_valid), 64'h1);
    chk("dec_first_pc", dec_pc, 64'h0);
    chk("dec_first_insn", 64'(dec_insn), 64'h1);
    step(20);
    chk("lin_req0", req_q[0], 64'h0);
    chk("lin_req1", req_q[1], 64'h8);
    chk("lin_req2", req_q[2], 64'h10);
    chk("lin_pc0", pc_q[0], 64'h0);
    chk("lin_pc1", pc_q[1], 64'h4);
    chk("lin_pc2", pc_q[2], 64'h8);
    chk("lin_pc3", pc_q[3], 64'hc);
    chk("lin_mask3", mask_q[3], 64'hffff_ffff_ffff_ffff);
    do_reset;
    dec_ready = 1'b0;
    reset = 1'b0;
    step(30);
    chk("stall_pops", 64'(pc_q.size()), 64'h0);
    chk("stall_head", dec_pc, 64'h0);
    chk("stall_reqs", 64'(req_q.size()), 64'h3);
    dec_ready = 1'b1;
    step(10);
    chk("resume_pc3", pc_q[3], 64'hc);
    chk("resume_pc4", pc_q[4], 64'h10);
    chk("resume_pc5", pc_q[5], 64'h14);
    do_reset;
    jmp_addr = 64'h4;
    reset = 1'b0;
    step(20);
    chk("jmp_pops", 64'(pc_q.size()), 64'h2);
    chk("jmp_pc1", pc_q[1], 64'h4);
    chk("jmp_reqs", 64'(req_q.size()), 64'h1);
    redirect(64'h0, 64'h3);
    chk("redir_not_yet", 64'(dec_valid), 64'h0);
    step(1);
    chk("redir_valid", 64'(dec_valid), 64'h1);
    chk("redir_pc", dec_pc, 64'h0);
    chk("redir_mask", dec_mask, 64'h3);
    step(10);
    chk("cached_reqs", 64'(req_q.size()), 64'h1);
    chk("cached_pc3", pc_q[3], 64'h4);
    chk("cached_mask3", mask_q[3], 64'h3);
    redirect(64'h100, 64'hf);
    step(10);
    chk("far_pc", pc_q[4], 64'h100);
    chk("far_mask", mask_q[4], 64'hf);
    chk("far_req", req_q[1], 64'h100);
    chk("far_pc_next", pc_q[5], 64'h104);
    chk("far_perr", 64'(protocol_error), 64'h0);
    do_reset;
    rsp_delay = 10;
    reset = 1'b0;
    step(30);
    chk("fill_wait", 64'(fill_wait_cycles), 64'ha);
    chk("fill_reqs", 64'(req_q.size()), 64'h1);
    chk("fill_pops", 64'(pc_q.size()), 64'h2);
    rsp_delay = 1;
    do_reset;
    chk("perr_rst_a", 64'(protocol_error), 64'h0);
    jmp_addr = 64'hfff0;
    dec_ready = 1'b0;
    reset = 1'b0;
    step(30);
    chk("perr_quiet", 64'(protocol_error), 64'h0);
    redirect(64'h200, 64'h1);
    chk("perr_check_redir", 64'(protocol_error), 64'h1);
    dec_ready = 1'b1;
    step(10);
    chk("ignored_pc0", pc_q[0], 64'h0);
    chk("ignored_pc4", pc_q[4], 64'h10);
    chk("ignored_mask4", mask_q[4], 64'hffff_ffff_ffff_ffff);
    chk("perr_sticky", 64'(protocol_error), 64'h1);
    do_reset;
    chk("perr_rst_b", 64'(protocol_error), 64'h0);
    jmp_addr = 64'h4;
    reset = 1'b0;
    step(20);
    redirect(64'h102, 64'h5);
    chk("perr_misalign", 64'(protocol_error), 64'h1);
    step(10);
    chk("misalign_pc", pc_q[2], 64'h100);
    chk("misalign_mask", mask_q[2], 64'h5);
    do_reset;
    reset = 1'b0;
    step(1);
    stray_rsp = 1'b1;
    step(1);
    stray_rsp = 1'b0;
    chk("perr_stray_rsp", 64'(protocol_error), 64'h1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
